// File: rtl/fpu_op_driver.sv
// Issue-side front end for the FPU: buffers operand/opcode triples in a FIFO, drives each one
// onto the FPU for LATENCY cycles, then captures the result into a valid/ready result port.
module fpu_op_driver #(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [1:0]       in_op,
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  output logic [1:0]       fpu_op,
  input  logic [31:0]      fpu_data_out,
  input  logic [3:0]       fpu_status_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [3:0]       res_status,
  output logic             busy,
  output logic [CNT_W-1:0] issued_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LAT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
  } triple_t;

  triple_t            mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [PTR_W:0]     count;
  logic [LAT_W-1:0]   lat_cnt;
  state_t             state, state_next;
  logic               push, issue, capture;

  // in_ready depends only on the registered count, never on res_ready.
  assign in_ready = (count != (PTR_W + 1)'(DEPTH));
  assign push     = in_valid && in_ready;
  assign busy     = (state != IDLE) || (count != '0);

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    capture    = 1'b0;
    unique case (state)
      IDLE: if (count != '0) begin
        issue      = 1'b1;
        state_next = WAIT;
      end
      WAIT: if (lat_cnt == LAT_W'(1)) begin
        capture    = 1'b1;
        state_next = HOLD;
      end
      HOLD: if (res_ready) begin
        if (count != '0) begin
          issue      = 1'b1;
          state_next = WAIT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: queue storage has no reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{a: in_a, b: in_b, op: in_op};
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      lat_cnt      <= '0;
      fpu_a        <= '0;
      fpu_b        <= '0;
      fpu_op       <= 2'b00;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_status   <= '0;
      issued_count <= '0;
    end else begin
      state <= state_next;
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, issue})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // Operands only move at an issue edge and are otherwise held, even in IDLE.
      if (issue) begin
        fpu_a        <= mem[rd_ptr].a;
        fpu_b        <= mem[rd_ptr].b;
        fpu_op       <= mem[rd_ptr].op;
        lat_cnt      <= LAT_W'(LATENCY);
        issued_count <= issued_count + 1'b1;
      end else if (state == WAIT) begin
        lat_cnt <= lat_cnt - 1'b1;
      end

      if (capture) begin
        res_data   <= fpu_data_out;
        res_status <= fpu_status_out;
        res_valid  <= 1'b1;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fpu_op_driver.sv
// Self-checking bench for fpu_op_driver: transaction-level timing model plus directed and
// randomized stimulus, with an adder stub standing in for the FPU.
module tb_fpu_op_driver;

  localparam int DEPTH   = 4;
  localparam int LATENCY = 8;
  localparam int CNT_W   = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_a = '0, in_b = '0;
  logic [1:0]       in_op = '0;
  logic [31:0]      fpu_a, fpu_b;
  logic [1:0]       fpu_op;
  logic [31:0]      fpu_data_out;
  logic [3:0]       fpu_status_out;
  logic             res_valid;
  logic             res_ready = 1'b1;
  logic [31:0]      res_data;
  logic [3:0]       res_status;
  logic             busy;
  logic [CNT_W-1:0] issued_count;

  logic             ovr = 1'b0;
  logic [31:0]      ovr_val = '0;

  assign fpu_data_out   = ovr ? ovr_val : fpu_a + fpu_b;
  assign fpu_status_out = {2'b00, fpu_op};

  fpu_op_driver #(.DEPTH(DEPTH), .LATENCY(LATENCY), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op),
    .fpu_data_out(fpu_data_out), .fpu_status_out(fpu_status_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_status(res_status),
    .busy(busy), .issued_count(issued_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: pending triples, the one in flight with its issue cycle, and the
  // last captured result. Results become visible LATENCY+1 cycles after the issue edge.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
  } trip_t;

  trip_t            mq[$];
  trip_t            cur;
  bit               have_op = 1'b0;
  int               iss_cyc = 0;
  logic [31:0]      m_a = '0, m_b = '0, m_data = '0;
  logic [1:0]       m_op = '0;
  logic [3:0]       m_status = '0;
  logic [CNT_W-1:0] m_cnt = '0;

  function automatic bit m_valid();
    return have_op && (cyc >= iss_cyc + LATENCY + 1);
  endfunction

  task automatic model_step();
    bit can_push;
    if (reset) begin
      mq.delete();
      have_op = 1'b0;
      m_a = '0; m_b = '0; m_op = '0;
      m_data = '0; m_status = '0; m_cnt = '0;
    end else begin
      can_push = (mq.size() < DEPTH);
      if (have_op && cyc == iss_cyc + LATENCY) begin
        m_data   = cur.a + cur.b;
        m_status = {2'b00, cur.op};
      end
      if (m_valid() && res_ready) have_op = 1'b0;
      if (!have_op && mq.size() > 0) begin
        cur     = mq.pop_front();
        have_op = 1'b1;
        iss_cyc = cyc;
        m_a = cur.a; m_b = cur.b; m_op = cur.op;
        m_cnt = m_cnt + 1'b1;
      end
      if (in_valid && can_push) mq.push_back('{a: in_a, b: in_b, op: in_op});
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("res_valid",    32'(res_valid),    32'(m_valid()));
      check("res_data",     res_data,          m_data);
      check("res_status",   32'(res_status),   32'(m_status));
      check("in_ready",     32'(in_ready),     32'(mq.size() < DEPTH));
      check("busy",         32'(busy),         32'(have_op || mq.size() > 0));
      check("fpu_a",        fpu_a,             m_a);
      check("fpu_b",        fpu_b,             m_b);
      check("fpu_op",       32'(fpu_op),       32'(m_op));
      check("issued_count", 32'(issued_count), 32'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    bit acc = 1'b0;
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
    for (int k = 0; k < 200 && !acc; k++) begin
      acc = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!acc) check("push_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!res_valid && n < 100) begin
      tick();
      n++;
    end
    check("res_valid_timeout", 32'(res_valid), 32'd1);
  endtask

  initial begin
    int c0;
    int t[3];

    reset = 1'b1;
    tick();
    chk_en = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_res_data", res_data,      32'd0);

    // Single op: valid exactly LATENCY+2 cycles after the push cycle.
    res_ready = 1'b1;
    c0 = cyc;
    push(32'h3E000000, 32'h3E000000, 2'b00);
    wait_valid();
    check("single_cycle",  32'(cyc - c0),      32'd10);
    check("single_data",   res_data,           32'h7C000000);
    check("single_status", 32'(res_status),    32'h0);
    tick();
    check("single_count",  32'(issued_count),  32'd1);
    check("single_busy",   32'(busy),          32'd0);

    // Fill and backpressure: one issued plus DEPTH queued, then full.
    res_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push(32'(i), 32'h10, 2'b01);
    check("fill_in_ready", 32'(in_ready), 32'd0);
    check("fill_busy",     32'(busy),     32'd1);
    res_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      wait_valid();
      check("fill_data",   res_data,         32'h10 + 32'(i));
      check("fill_status", 32'(res_status),  32'h1);
      tick();
    end

    // Back-to-back: results every LATENCY+1 cycles.
    for (int k = 0; k < 4; k++) tick();
    c0 = cyc;
    for (int i = 0; i < 3; i++) push(32'h100 * 32'(i + 1), 32'h7, 2'b10);
    for (int i = 0; i < 3; i++) begin
      wait_valid();
      t[i] = cyc - c0;
      tick();
    end
    check("b2b_first",  32'(t[0]), 32'd10);
    check("b2b_second", 32'(t[1]), 32'd19);
    check("b2b_third",  32'(t[2]), 32'd28);

    // HOLD stability: FPU output wanders but the captured result stays put.
    res_ready = 1'b0;
    push(32'h12340000, 32'h00005678, 2'b11);
    wait_valid();
    ovr = 1'b1;
    for (int k = 0; k < 20; k++) begin
      ovr_val = $urandom;
      tick();
      check("hold_data",   res_data,        32'h12345678);
      check("hold_status", 32'(res_status), 32'h3);
    end
    ovr = 1'b0;
    res_ready = 1'b1;
    tick();

    // Reset mid-WAIT drops everything.
    c0 = cyc;
    push(32'hA, 32'hB, 2'b01);
    push(32'hC, 32'hD, 2'b01);
    for (int k = 0; k < 20 && cyc < c0 + 5; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_valid",    32'(res_valid),    32'd0);
    check("mid_rst_busy",     32'(busy),         32'd0);
    check("mid_rst_count",    32'(issued_count), 32'd0);
    check("mid_rst_fpu_a",    fpu_a,             32'd0);
    check("mid_rst_in_ready", 32'(in_ready),     32'd1);
    for (int k = 0; k < 30; k++) begin
      tick();
      check("mid_rst_no_result", 32'(res_valid), 32'd0);
    end

    // Counter wrap with a 4-bit counter: 17 issues read back as 1.
    for (int i = 0; i < 17; i++) push(32'(i), 32'(i * 3), 2'(i));
    for (int k = 0; k < 2000 && busy; k++) tick();
    check("wrap_count", 32'(issued_count), 32'd1);
    check("wrap_idle",  32'(busy),         32'd0);

    // Random traffic with random backpressure, checked against the model every cycle.
    for (int k = 0; k < 600; k++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_a      = $urandom;
      in_b      = $urandom;
      in_op     = 2'($urandom_range(0, 3));
      res_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    for (int k = 0; k < 500 && busy; k++) tick();
    check("drain_idle", 32'(busy), 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
